axi_sram_responder: RTL
=======================

# axi_sram_responder

AXI4-Lite subordinate that terminates a memory-side AXI bus and drives a single-port synchronous SRAM. It is the responder counterpart of the core's SRAM-to-AXI initiator adapters, so a CPU bus port can be tied straight to on-chip RAM in simulation and FPGA builds. The block serialises reads and writes onto the one SRAM port, holding each response until the initiator accepts it.

## Interface
- `SRAM_AW`, 16: SRAM word-address width; depth is 2^SRAM_AW 32-bit words.
- `ROM_TOP`, 32'h0000_0000: byte address below which writes are suppressed (only used with `AXI_SRAM_WPROT_EN`).
- `g_clk` in 1: global clock; all logic on the rising edge.
- `g_reset` in 1: reset, synchronous, active-high.
- `axi_awvalid` in 1 / `axi_awready` out 1 / `axi_awaddr` in 32 / `axi_awprot` in 3: write address channel (prot ignored).
- `axi_wvalid` in 1 / `axi_wready` out 1 / `axi_wdata` in 32 / `axi_wstrb` in 4: write data channel.
- `axi_bvalid` out 1 / `axi_bready` in 1: write response.
- `axi_arvalid` in 1 / `axi_arready` out 1 / `axi_araddr` in 32 / `axi_arprot` in 3: read address channel (prot ignored).
- `axi_rvalid` out 1 / `axi_rready` in 1 / `axi_rdata` out 32: read data.
- `sram_cen` out 1: SRAM chip enable, one-cycle pulse per access.
- `sram_wen` out 1: 1 = write, 0 = read; meaningful only with `sram_cen`.
- `sram_addr` out SRAM_AW: word address.
- `sram_strb` out 4 / `sram_wdata` out 32: byte enables and write data.
- `sram_rdata` in 32: read data, valid the cycle after a read `sram_cen`.
- `wr_blocked` out 1: one-cycle pulse when a write is suppressed (tied 0 without `AXI_SRAM_WPROT_EN`).

## Operation
- FSM states: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP. Reset state IDLE.
- A write is eligible only when `axi_awvalid` and `axi_wvalid` are both high; AW and W are always accepted in the same cycle. A lone AW or W is not accepted.
- Read is eligible when `axi_arvalid` is high.
- Arbitration in IDLE: if only one request is eligible, it wins. If both are, a priority bit chooses; it resets to read and flips to the other type after every contested grant.
- Grant read: `axi_arready`=1 in that IDLE cycle, register `araddr[SRAM_AW+1:2]`, go to RD_REQ.
- Grant write: `axi_awready`=`axi_wready`=1, register address, data and strobe, go to WR_REQ.
- Readies are combinational on valid and state, asserted only in IDLE for the granted request.
- RD_REQ: `sram_cen`=1, `sram_wen`=0, then RD_RESP.
- RD_RESP: first cycle captures `sram_rdata` into the `axi_rdata` register. `axi_rvalid`=1 and stays high with stable data until `axi_rready`, then returns to IDLE.
- WR_REQ: `sram_cen`=1, `sram_wen`=1, with `sram_strb`/`sram_wdata` from the registers, then WR_RESP.
- WR_RESP: `axi_bvalid`=1 until `axi_bready`, then IDLE.
- Address bits `[31:SRAM_AW+2]` and `[1:0]` are ignored, so addresses alias modulo the depth.
- A write with `wstrb`=0 still performs an SRAM access with a zero strobe and returns a response.

## Timing
- Reset values: all `*ready`, `axi_bvalid`, `axi_rvalid`, `sram_cen`, `sram_wen` and `wr_blocked` are 0. `axi_rdata`, `sram_addr`, `sram_strb` and `sram_wdata` are 0. Priority bit = read.
- Read: AR handshake in cycle N, SRAM read in N+1, `axi_rvalid` first high in N+2.
- Write: AW/W handshake in cycle N, SRAM write in N+1, `axi_bvalid` first high in N+2.
- Back-to-back: a ready in cycle N+2 returns the FSM to IDLE in N+3, so the next grant is no earlier than N+3. Throughput is one transaction per 3 cycles.
- No outstanding transactions: at most one access is in flight at any time.
- Reset asserted mid-operation: the FSM goes to IDLE the next edge, any pending response is dropped, and a half-issued SRAM write is not retried.

## Configuration
- `AXI_SRAM_WPROT_EN` defined: a granted write whose registered byte address is below `ROM_TOP` does not assert `sram_cen` in WR_REQ. `wr_blocked` pulses in that cycle and `axi_bvalid` is still returned with unchanged timing.
- Undefined: all writes reach the SRAM and `wr_blocked` is constant 0.

## Test plan
- Write 0xDEADBEEF to 0x10 with strb 0xF, then read 0x10 → `rvalid` two cycles after AR handshake, `rdata`=0xDEADBEEF.
- Write 0x000000AA with strb 0x1 over 0x11223344 → read back 0x112233AA.
- AR, AW and W all valid in the same IDLE cycle after reset → read granted first. Repeat the contested case → write granted next.
- Hold `rready`=0 for 5 cycles → `rvalid` and `rdata` stable throughout, no new grant.
- Assert `g_reset` during WR_RESP → `bvalid`=0 the next cycle, FSM in IDLE.
- With `AXI_SRAM_WPROT_EN` and `ROM_TOP`=0x100, write 0x55 to 0x40 → `wr_blocked` pulses, `bvalid` returned, read of 0x40 returns the old value.

Source files
------------

// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI4-Lite subordinate serialising reads and writes onto one synchronous SRAM port
// Optional write protection below ROM_TOP is enabled by defining AXI_SRAM_WPROT_EN.
module axi_sram_responder #(
    parameter int          SRAM_AW = 16,
    parameter logic [31:0] ROM_TOP = 32'h0000_0000
) (
    input  logic               g_clk,
    input  logic               g_reset,

    input  logic               axi_awvalid,
    output logic               axi_awready,
    input  logic [31:0]        axi_awaddr,
    input  logic [2:0]         axi_awprot,

    input  logic               axi_wvalid,
    output logic               axi_wready,
    input  logic [31:0]        axi_wdata,
    input  logic [3:0]         axi_wstrb,

    output logic               axi_bvalid,
    input  logic               axi_bready,

    input  logic               axi_arvalid,
    output logic               axi_arready,
    input  logic [31:0]        axi_araddr,
    input  logic [2:0]         axi_arprot,

    output logic               axi_rvalid,
    input  logic               axi_rready,
    output logic [31:0]        axi_rdata,

    output logic               sram_cen,
    output logic               sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [3:0]         sram_strb,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,

    output logic               wr_blocked
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               prio_wr_q, prio_wr_d;    // 0: read wins the next contested cycle
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [3:0]         strb_q, strb_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rd_first_q, rd_first_d;  // high in the first RD_RESP cycle, when SRAM data is live

    logic wr_elig;
    logic rd_elig;
    logic grant_rd;
    logic grant_wr;
    logic wr_block;

    // Address bits outside the word index and the prot fields carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{axi_awprot, axi_arprot,
                             axi_awaddr[31:SRAM_AW+2], axi_awaddr[1:0],
                             axi_araddr[31:SRAM_AW+2], axi_araddr[1:0]};

    assign wr_elig  = axi_awvalid & axi_wvalid;
    assign rd_elig  = axi_arvalid;
    assign grant_rd = (state_q == S_IDLE) & rd_elig & (~wr_elig | ~prio_wr_q);
    assign grant_wr = (state_q == S_IDLE) & wr_elig & (~rd_elig | prio_wr_q);

`ifdef AXI_SRAM_WPROT_EN
    // Compare the aliased byte address so every alias of the protected region stays protected.
    logic [31:0] wr_byte_addr;
    assign wr_byte_addr = 32'({addr_q, 2'b00});
    assign wr_block     = (wr_byte_addr < ROM_TOP);
`else
    logic unused_rom_top;
    assign unused_rom_top = ^ROM_TOP;
    assign wr_block       = 1'b0;
`endif

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one access in flight, each response held until accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_rd) begin
                    state_d = S_RD_REQ;
                end else if (grant_wr) begin
                    state_d = S_WR_REQ;
                end
            end
            S_RD_REQ:  state_d = S_RD_RESP;
            S_RD_RESP: if (axi_rready) state_d = S_IDLE;
            S_WR_REQ:  state_d = S_WR_RESP;
            S_WR_RESP: if (axi_bready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic: readies only in IDLE for the granted request, SRAM strobes in the REQ states.
    always_comb begin
        axi_arready = grant_rd;
        axi_awready = grant_wr;
        axi_wready  = grant_wr;
        axi_rvalid  = (state_q == S_RD_RESP);
        axi_bvalid  = (state_q == S_WR_RESP);
        sram_wen    = (state_q == S_WR_REQ);
        sram_cen    = (state_q == S_RD_REQ) | ((state_q == S_WR_REQ) & ~wr_block);
        wr_blocked  = (state_q == S_WR_REQ) & wr_block;
    end

    // Datapath next values: capture request fields on grant, SRAM data on the first response cycle.
    always_comb begin
        addr_d     = addr_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        prio_wr_d  = prio_wr_q;
        rd_first_d = (state_q == S_RD_REQ);
        if (grant_rd) begin
            addr_d = axi_araddr[SRAM_AW+1:2];
        end else if (grant_wr) begin
            addr_d  = axi_awaddr[SRAM_AW+1:2];
            strb_d  = axi_wstrb;
            wdata_d = axi_wdata;
        end
        if ((grant_rd | grant_wr) & rd_elig & wr_elig) begin
            prio_wr_d = ~prio_wr_q;
        end
        if (rd_first_q) begin
            rdata_d = sram_rdata;
        end
    end

    // Datapath registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            addr_q     <= '0;
            strb_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            prio_wr_q  <= 1'b0;
            rd_first_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            prio_wr_q  <= prio_wr_d;
            rd_first_q <= rd_first_d;
        end
    end

    // SRAM data is presented directly in the first response cycle so rvalid can rise two cycles
    // after the AR handshake; afterwards the captured copy keeps rdata stable under backpressure.
    assign axi_rdata  = rd_first_q ? sram_rdata : rdata_q;
    assign sram_addr  = addr_q;
    assign sram_strb  = strb_q;
    assign sram_wdata = wdata_q;

endmodule
